// File: rtl/seq_magnitude_comparator_if.sv
// Request/result bundle of the sequential magnitude comparator.
// master drives operands and start, slave returns status and result.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sgn;
  logic             Gi;
  logic             Ei;
  logic             Li;
  logic             busy;
  logic             done;
  logic             Go;
  logic             Eo;
  logic             Lo;

  modport master (
    output start, a, b, sgn, Gi, Ei, Li,
    input  busy, done, Go, Eo, Lo
  );

  modport slave (
    input  start, a, b, sgn, Gi, Ei, Li,
    output busy, done, Go, Eo, Lo
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Width-generic magnitude comparator, one DIGIT-bit slice per clock,
// MSB slice first, 74x85-style cascade inputs resolve full equality.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic clk,
  input  logic rst,
  seq_magnitude_comparator_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] TOP = IW'(NDIG - 1);

  typedef enum logic {
    IDLE,
    COMPARE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic             gi_q;
  logic             ei_q;
  logic             li_q;
  logic             go_q;
  logic             eo_q;
  logic             lo_q;
  logic             done_q;

  logic [DIGIT-1:0] sa;
  logic [DIGIT-1:0] sb;
  logic             accept;
  logic             top;
  logic             sign_split;
  logic             fin;
  logic             res_g;
  logic             res_e;
  logic             res_l;

  assign sa     = a_q[int'(idx_q)*DIGIT +: DIGIT];
  assign sb     = b_q[int'(idx_q)*DIGIT +: DIGIT];
  assign accept = (state_q == IDLE) && bus.start;
  assign top    = (idx_q == TOP);

  // Opposite signs in signed mode decide on the top slice alone.
  assign sign_split = sgn_q && top &&
                      (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave COMPARE once a result is decided.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = COMPARE;
      COMPARE: if (fin)       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slice decision and cascade resolution for the current slice.
  always_comb begin
    fin   = 1'b0;
    res_g = 1'b0;
    res_e = 1'b0;
    res_l = 1'b0;
    if (state_q == COMPARE) begin
      if (sign_split) begin
        fin   = 1'b1;
        res_g = b_q[WIDTH-1];
        res_l = a_q[WIDTH-1];
      end else if (sa > sb) begin
        fin   = 1'b1;
        res_g = 1'b1;
      end else if (sa < sb) begin
        fin   = 1'b1;
        res_l = 1'b1;
      end else if (idx_q == '0) begin
        fin = 1'b1;
        if (ei_q)      res_e = 1'b1;
        else if (gi_q) res_g = 1'b1;
        else if (li_q) res_l = 1'b1;
        else           res_e = 1'b1;
      end
    end
  end

  // Capture operands on accept, walk the slice index downward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= TOP;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      gi_q  <= 1'b0;
      ei_q  <= 1'b0;
      li_q  <= 1'b0;
    end else if (accept) begin
      idx_q <= TOP;
      a_q   <= bus.a;
      b_q   <= bus.b;
      sgn_q <= bus.sgn;
      gi_q  <= bus.Gi;
      ei_q  <= bus.Ei;
      li_q  <= bus.Li;
    end else if (state_q == COMPARE && !fin) begin
      idx_q <= idx_q - 1'b1;
    end
  end

  // Result registers hold until the next decision; done pulses once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q   <= 1'b0;
      eo_q   <= 1'b0;
      lo_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        go_q <= res_g;
        eo_q <= res_e;
        lo_q <= res_l;
      end
    end
  end

  assign bus.busy = (state_q == COMPARE);
  assign bus.done = done_q;
  assign bus.Go   = go_q;
  assign bus.Eo   = eo_q;
  assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench for seq_magnitude_comparator, NDIG=4 and NDIG=1.
// Results are packed {Go,Eo,Lo} and checked against hand values.
module tb_seq_magnitude_comparator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  seq_magnitude_comparator_if #(.WIDTH(16)) bus4 ();
  seq_magnitude_comparator_if #(.WIDTH(16)) bus1 ();

  seq_magnitude_comparator #(
    .WIDTH(16),
    .DIGIT(4)
  ) dut4 (
    .clk(clk),
    .rst(rst),
    .bus(bus4)
  );

  seq_magnitude_comparator #(
    .WIDTH(16),
    .DIGIT(16)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  localparam logic [2:0] R_G = 3'b100;
  localparam logic [2:0] R_E = 3'b010;
  localparam logic [2:0] R_L = 3'b001;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] prev4 = 3'b000;
  logic [2:0] prev1 = 3'b000;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic gi,
                         input logic ei, input logic li);
    bus4.a = a;  bus4.b = b;  bus4.sgn = s;
    bus4.Gi = gi; bus4.Ei = ei; bus4.Li = li;
    bus1.a = a;  bus1.b = b;  bus1.sgn = s;
    bus1.Gi = gi; bus1.Ei = ei; bus1.Li = li;
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) bus1.start = v;
    else     bus4.start = v;
  endtask

  function automatic logic [2:0] res(input bit sel);
    if (sel) return {bus1.Go, bus1.Eo, bus1.Lo};
    return {bus4.Go, bus4.Eo, bus4.Lo};
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? bus1.busy : bus4.busy;
  endfunction

  function automatic logic done_of(input bit sel);
    return sel ? bus1.done : bus4.done;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmp(input string tag, input bit sel,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic gi,
                         input logic ei, input logic li,
                         input logic [2:0] exp, input int k);
    logic [2:0] prev;
    int cyc;
    bit seen;
    prev = sel ? prev1 : prev4;
    set_ops(a, b, s, gi, ei, li);
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    check({tag, ".busy"}, 32'(busy_of(sel)), 32'd1);
    check({tag, ".hold"}, 32'(res(sel)), 32'(prev));
    seen = 1'b0;
    cyc  = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done_of(sel)) begin
        seen = 1'b1;
        cyc  = i;
        break;
      end
    end
    check({tag, ".lat"}, seen ? 32'(cyc) : 32'd0, 32'(k));
    check({tag, ".res"}, 32'(res(sel)), 32'(exp));
    check({tag, ".idle"}, 32'(busy_of(sel)), 32'd0);
    tick();
    check({tag, ".pulse"}, 32'(done_of(sel)), 32'd0);
    if (sel) prev1 = exp;
    else     prev4 = exp;
  endtask

  initial begin
    int dcount;
    bus4.start = 1'b0;
    bus1.start = 1'b0;
    set_ops(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    #2 rst = 1'b1;
    #1;
    check("rst.busy", 32'(bus4.busy), 32'd0);
    check("rst.done", 32'(bus4.done), 32'd0);
    check("rst.res4", 32'(res(1'b0)), 32'd0);
    check("rst.res1", 32'(res(1'b1)), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    run_cmp("u_early", 0, 16'h8000, 16'h7FFF, 0, 0, 0, 0, R_G, 1);
    run_cmp("u_lo", 0, 16'h1234, 16'h1235, 0, 0, 0, 0, R_L, 4);
    run_cmp("u_go", 0, 16'h1235, 16'h1234, 0, 0, 0, 0, R_G, 4);

    run_cmp("c_e", 0, 16'hABCD, 16'hABCD, 0, 0, 1, 0, R_E, 4);
    run_cmp("c_g", 0, 16'hABCD, 16'hABCD, 0, 1, 0, 0, R_G, 4);
    run_cmp("c_l", 0, 16'hABCD, 16'hABCD, 0, 0, 0, 1, R_L, 4);
    run_cmp("c_0", 0, 16'hABCD, 16'hABCD, 0, 0, 0, 0, R_E, 4);

    run_cmp("s_neg", 0, 16'h8000, 16'h0001, 1, 0, 0, 0, R_L, 1);
    run_cmp("s_ff", 0, 16'hFFFF, 16'hFFFE, 1, 0, 0, 0, R_G, 4);
    run_cmp("u_ff", 0, 16'hFFFF, 16'hFFFE, 0, 0, 0, 0, R_G, 4);

    // start stays high and operands churn while busy
    set_ops(16'h1234, 16'h1234, 0, 0, 1, 0);
    bus4.start = 1'b1;
    tick();
    check("hs.busy", 32'(bus4.busy), 32'd1);
    dcount = 0;
    set_ops(16'hFFFF, 16'h0000, 1, 0, 0, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (bus4.done) dcount++;
      if (c < 4) begin
        set_ops(16'(c * 16'h0F0F), 16'(c * 16'h3030),
                c[0], 1, 0, 0);
      end else begin
        bus4.start = 1'b0;
      end
    end
    check("hs.done", 32'(bus4.done), 32'd1);
    check("hs.res", 32'(res(1'b0)), 32'(R_E));
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus4.done) dcount++;
    end
    check("hs.count", 32'(dcount), 32'd1);
    check("hs.keep", 32'(res(1'b0)), 32'(R_E));
    check("hs.idle", 32'(bus4.busy), 32'd0);
    prev4 = R_E;

    // start held through done is accepted immediately
    set_ops(16'h8000, 16'h7FFF, 0, 0, 0, 0);
    bus4.start = 1'b1;
    tick();
    check("b2b.busy0", 32'(bus4.busy), 32'd1);
    tick();
    check("b2b.done0", 32'(bus4.done), 32'd1);
    check("b2b.res0", 32'(res(1'b0)), 32'(R_G));
    set_ops(16'h0001, 16'h8000, 0, 0, 0, 0);
    tick();
    bus4.start = 1'b0;
    check("b2b.busy1", 32'(bus4.busy), 32'd1);
    check("b2b.nodone", 32'(bus4.done), 32'd0);
    check("b2b.hold", 32'(res(1'b0)), 32'(R_G));
    tick();
    check("b2b.done1", 32'(bus4.done), 32'd1);
    check("b2b.res1", 32'(res(1'b0)), 32'(R_L));
    tick();
    check("b2b.pulse", 32'(bus4.done), 32'd0);
    prev4 = R_L;

    // reset two cycles into a four-slice compare
    set_ops(16'h1234, 16'h1235, 0, 0, 0, 0);
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mrst.busy", 32'(bus4.busy), 32'd0);
    check("mrst.done", 32'(bus4.done), 32'd0);
    check("mrst.res", 32'(res(1'b0)), 32'd0);
    tick();
    check("mrst.held", 32'(bus4.done), 32'd0);
    rst = 1'b0;
    prev4 = 3'b000;
    run_cmp("post_rst", 0, 16'h0003, 16'h0003, 0, 0, 1, 0, R_E, 4);

    run_cmp("n1_early", 1, 16'h8000, 16'h7FFF, 0, 0, 0, 0, R_G, 1);
    run_cmp("n1_eq", 1, 16'h5A5A, 16'h5A5A, 0, 0, 0, 1, R_L, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_magnitude_comparator.md
# seq_magnitude_comparator

Parametrised, multi-cycle magnitude comparator. Compares two WIDTH-bit operands one DIGIT-bit slice per clock, most-significant slice first. It stops as soon as a slice differs and resolves full equality through 74x85-style cascade inputs. It is the clocked, width-generic successor of the team's 4-bit cascadable comparator, adds optional two's-complement ordering and a start/busy/done handshake, and sits wherever wide compares must share one narrow slice comparator.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT (≥1).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- sgn  in  1  1 = two's-complement compare, 0 = unsigned; captured on accepted start.
- Gi  in  1  cascade "greater" from lower-order stage; captured on accepted start.
- Ei  in  1  cascade "equal" from lower-order stage; captured on accepted start.
- Li  in  1  cascade "less" from lower-order stage; captured on accepted start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when a new result becomes valid.
- Go  out  1  A > B.
- Eo  out  1  A = B.
- Lo  out  1  A < B.

## Operation
- States: IDLE, COMPARE. Slice index idx counts NDIG-1 down to 0.
- IDLE, start=1: latch a, b, sgn, Gi, Ei, Li. Set idx=NDIG-1 and busy=1, then go to COMPARE. Go/Eo/Lo keep their previous result until the new one is written.
- COMPARE, each cycle, slice s = bits [idx*DIGIT+DIGIT-1 : idx*DIGIT] of the latched operands:
  - Top slice with sgn=1 and sign bits differing: the operand with sign 0 is greater. Decision is made.
  - Otherwise compare the slices unsigned. This holds for the top slice in signed mode too, since equal signs preserve unsigned order.
  - Slices unequal: write the one-hot result, go to IDLE.
  - Slices equal and idx>0: decrement idx, stay in COMPARE.
  - Slices equal and idx=0: resolve from the latched cascade inputs, go to IDLE.
- Cascade resolution priority: Ei=1 gives Eo. Else Gi=1 gives Go. Else Li=1 gives Lo. Else (all 0) gives Eo.
- Go/Eo/Lo are always one-hot after the first completed compare, and hold until the next result is written.
- start while busy is ignored; there is no queueing. Changes on a/b/sgn/cascade inputs after capture have no effect on the compare in progress.

## Timing
- Reset (asynchronous, immediate): state=IDLE, idx=NDIG-1, busy=0, done=0, Go=0, Eo=0, Lo=0.
- Start accepted at edge T:
  - busy=1 from T.
  - Slice NDIG-1 is evaluated during the cycle after T.
- Result examining k slices (1 ≤ k ≤ NDIG):
  - Go/Eo/Lo are updated at edge T+k.
  - done=1 for exactly the cycle following T+k, and busy=0 from T+k.
  - Latency is 1 cycle minimum (top slice differs) and NDIG cycles maximum (equal or differing only in slice 0).
- Back-to-back operation: start held high while done=1 is accepted at that edge, so the next compare begins immediately.
- Reset mid-compare: the compare is aborted, all outputs return to reset values, and no done is produced. The next start behaves normally.
- NDIG=1: every compare takes exactly 1 cycle.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated otherwise.
- Unsigned early exit: a=0x8000, b=0x7FFF, sgn=0 -> Go=1, Eo=0, Lo=0; done one cycle after start edge; busy high 1 cycle.
- Unsigned full scan: a=0x1234, b=0x1235 -> Lo=1 after 4 cycles; then a=0x1235, b=0x1234 -> Go=1 after 4 cycles.
- Cascade resolution: a=b=0xABCD:
  - Gi=0, Ei=1, Li=0 -> Eo=1 after 4 cycles.
  - Ei=0, Gi=1 -> Go=1.
  - Ei=0, Gi=0, Li=1 -> Lo=1.
  - Gi=Ei=Li=0 -> Eo=1.
- Signed mode: sgn=1:
  - a=0x8000, b=0x0001 -> Lo=1 in 1 cycle.
  - a=0xFFFF, b=0xFFFE -> Go=1 in 4 cycles.
  - Same pair with sgn=0 -> Go=1 in 4 cycles.
- Handshake: pulse start, then assert start and change a/b every cycle while busy. Required: result reflects the first capture only, done pulses once, and outputs hold unchanged 5 idle cycles later. Separately, start held through done is accepted back-to-back.
- Reset: assert rst two cycles into a 4-slice compare -> busy, done, Go, Eo, Lo all read 0 immediately; the following start of a=0x0003, b=0x0003 with Ei=1 gives Eo=1 after 4 cycles. Also rerun the unsigned early-exit case with DIGIT=16 (NDIG=1) -> Go=1 in 1 cycle.
